if_id_branch_stage: RTL and testbench

- IF/ID pipeline register of the RISCV64 core; the consumer of `IF_ID_cstall` (the control-stall request) and of the load-use hazard stall.
- Owns the stall/bubble sequencing for branches. A branch detected in ID holds the PC and injects NOPs until EX resolves it. On resolution it issues a one-cycle PC redirect or releases the fall-through fetch.
- Also supports a trap flush, a resolution watchdog and a saturating count of control bubbles.

---
 rtl/if_id_branch_stage.sv | 136 +++++++++++++
 tb/tb_if_id_branch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_branch_stage.sv
// IF/ID pipeline register with branch stall/bubble sequencing, trap flush,
// branch-resolution watchdog and a saturating control-bubble counter.
module if_id_branch_stage #(
  parameter int          XLEN     = 64,
  parameter int          MAX_WAIT = 4,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  input  logic             IF_ID_cstall,
  input  logic             hstall,
  input  logic             flush,
  input  logic             br_resolved,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             pc_hold,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             err_timeout,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic {S_RUN, S_WAIT_BR} state_t;

  localparam logic [3:0] LP_WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic [XLEN-1:0]  r_id_pc, r_redirect_pc;
  logic [31:0]      r_id_instr;
  logic             r_id_valid, r_pc_redirect, r_err_timeout;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_ld_bubble, w_ld_fetch, w_cnt_inc, w_redirect, w_timeout, w_pc_hold;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ld_bubble    = 1'b0;
    w_ld_fetch     = 1'b0;
    w_cnt_inc      = 1'b0;
    w_redirect     = 1'b0;
    w_timeout      = 1'b0;
    w_pc_hold      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (flush) begin
          w_ld_bubble = 1'b1;
        end else if (hstall) begin
          w_pc_hold = 1'b1;
        end else if (IF_ID_cstall && r_id_valid) begin
          // Branch leaves for EX; fall-through stays parked in IF.
          w_ld_bubble    = 1'b1;
          w_cnt_inc      = 1'b1;
          w_pc_hold      = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_WAIT_BR;
        end else begin
          w_ld_fetch = 1'b1;
        end
      end
      S_WAIT_BR: begin
        w_state_nxt = S_RUN;
        if (flush) begin
          w_ld_bubble = 1'b1;
        end else if (br_resolved && br_taken) begin
          w_ld_bubble = 1'b1;
          w_cnt_inc   = 1'b1;
          w_redirect  = 1'b1;
        end else if (br_resolved) begin
          w_ld_fetch = 1'b1;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          // Give up waiting and let fetch resume at the fall-through.
          w_timeout   = 1'b1;
          w_ld_bubble = 1'b1;
        end else begin
          w_ld_bubble    = 1'b1;
          w_cnt_inc      = 1'b1;
          w_pc_hold      = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          w_state_nxt    = S_WAIT_BR;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_id_pc       <= '0;
      r_id_instr    <= NOP;
      r_id_valid    <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_redirect_pc <= '0;
      r_err_timeout <= 1'b0;
      r_bubble_cnt  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_pc_redirect <= w_redirect;
      if (w_redirect)
        r_redirect_pc <= br_target;
      if (w_timeout)
        r_err_timeout <= 1'b1;
      if (w_cnt_inc && (r_bubble_cnt != {CNT_W{1'b1}}))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_ld_bubble) begin
        r_id_instr <= NOP;
        r_id_valid <= 1'b0;
      end else if (w_ld_fetch) begin
        r_id_pc    <= if_pc;
        r_id_instr <= if_instr;
        r_id_valid <= if_valid;
      end
    end
  end

  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign id_valid    = r_id_valid;
  assign pc_hold     = w_pc_hold;
  assign pc_redirect = r_pc_redirect;
  assign redirect_pc = r_redirect_pc;
  assign err_timeout = r_err_timeout;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_branch_stage.sv
// Self-checking bench for if_id_branch_stage: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_if_id_branch_stage;

  localparam int          XLEN     = 64;
  localparam int          MAX_WAIT = 4;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [XLEN-1:0]  if_pc, br_target;
  logic [31:0]      if_instr;
  logic             if_valid, IF_ID_cstall, hstall, flush, br_resolved, br_taken;
  logic [XLEN-1:0]  id_pc, redirect_pc;
  logic [31:0]      id_instr;
  logic             id_valid, pc_hold, pc_redirect, err_timeout;
  logic [CNT_W-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  bit          m_wait;
  int          m_wc;
  logic [63:0] m_pc, m_rpc;
  logic [31:0] m_instr;
  bit          m_valid, m_redir, m_err;
  int          m_cnt;

  if_id_branch_stage #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .IF_ID_cstall(IF_ID_cstall), .hstall(hstall), .flush(flush),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .pc_hold(pc_hold),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .err_timeout(err_timeout),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_regs();
    chk("id_instr", 64'(id_instr), 64'(m_instr));
    chk("id_valid", 64'(id_valid), 64'(m_valid));
    if (m_valid) chk("id_pc", id_pc, m_pc);
    chk("pc_redirect", 64'(pc_redirect), 64'(m_redir));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
  endtask

  // Called at a negedge: asserts reset asynchronously and checks the outputs at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    {flush, hstall, IF_ID_cstall, br_resolved, br_taken, if_valid} = '0;
    if_pc = '0; if_instr = '0; br_target = '0;
    m_wait = 0; m_wc = 0; m_pc = '0; m_rpc = '0; m_instr = NOP;
    m_valid = 0; m_redir = 0; m_err = 0; m_cnt = 0;
    #1;
    chk_regs();
    chk("rst_id_pc", id_pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; entered and left at a negedge.
  task automatic step(input bit fl, input bit hs, input bit cs, input bit rs, input bit tk,
                      input logic [63:0] tgt, input logic [63:0] pc, input logic [31:0] ins,
                      input bit vld);
    bit hold, bubble, adv;
    flush = fl; hstall = hs; IF_ID_cstall = cs; br_resolved = rs; br_taken = tk;
    br_target = tgt; if_pc = pc; if_instr = ins; if_valid = vld;
    hold = 0; bubble = 0; adv = 0;
    m_redir = 0;
    if (!m_wait) begin
      if (fl) bubble = 1;
      else if (hs) hold = 1;
      else if (cs && m_valid) begin
        bubble = 1; hold = 1; m_cnt++; m_wc = 0; m_wait = 1;
      end else adv = 1;
    end else begin
      m_wait = 0;
      if (fl) bubble = 1;
      else if (rs && tk) begin bubble = 1; m_cnt++; m_redir = 1; m_rpc = tgt; end
      else if (rs) adv = 1;
      else if (m_wc == MAX_WAIT - 1) begin m_err = 1; bubble = 1; end
      else begin bubble = 1; hold = 1; m_cnt++; m_wc++; m_wait = 1; end
    end
    if (m_cnt > 15) m_cnt = 15;
    if (bubble) begin m_instr = NOP; m_valid = 0; end
    else if (adv) begin m_pc = pc; m_instr = ins; m_valid = vld; end
    #1;
    chk("pc_hold", 64'(pc_hold), 64'(hold));
    @(negedge clk);
    chk_regs();
  endtask

  task automatic load(input logic [63:0] pc);
    step(0, 0, 0, 0, 0, 64'h0, pc, 32'h00a00093, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // not-taken branch
    load(64'h1000);
    step(0, 0, 1, 0, 0, 64'h0, 64'h1004, 32'h00108113, 1);
    step(0, 0, 0, 0, 0, 64'h0, 64'h1004, 32'h00108113, 1);
    step(0, 0, 0, 1, 0, 64'h0, 64'h1004, 32'h00108113, 1);
    chk("nt_id_pc", id_pc, 64'h1004);
    chk("nt_valid", 64'(id_valid), 64'h1);
    chk("nt_cnt", 64'(bubble_cnt), 64'h2);

    // taken branch
    do_reset();
    load(64'h1000);
    step(0, 0, 1, 0, 0, 64'h0, 64'h1004, 32'h00108113, 1);
    step(0, 0, 0, 1, 1, 64'h2000, 64'h1004, 32'h00108113, 1);
    chk("tk_redir", 64'(pc_redirect), 64'h1);
    chk("tk_rpc", redirect_pc, 64'h2000);
    step(0, 0, 0, 0, 0, 64'h0, 64'h2000, 32'h00310193, 1);
    chk("tk_redir_off", 64'(pc_redirect), 64'h0);
    chk("tk_id_pc", id_pc, 64'h2000);
    chk("tk_cnt", 64'(bubble_cnt), 64'h2);

    // hazard stall takes precedence over the branch
    do_reset();
    load(64'h3000);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 64'h0, 64'h3004 + 64'(4 * i), 32'h00418213, 1);
      chk("hz_id_pc", id_pc, 64'h3000);
    end
    step(0, 0, 1, 0, 0, 64'h0, 64'h3004, 32'h00418213, 1);
    chk("hz_cnt", 64'(bubble_cnt), 64'h1);

    // flush beats a taken resolution in the same cycle
    step(1, 0, 0, 1, 1, 64'h4000, 64'h3004, 32'h00418213, 1);
    chk("fl_redir", 64'(pc_redirect), 64'h0);
    load(64'h5000);
    chk("fl_run", 64'(id_valid), 64'h1);

    // watchdog: stays sticky through a later branch
    do_reset();
    load(64'h6000);
    step(0, 0, 1, 0, 0, 64'h0, 64'h6004, 32'h0, 1);
    for (int i = 0; i < MAX_WAIT; i++) step(0, 0, 0, 0, 0, 64'h0, 64'h6004, 32'h0, 1);
    chk("wd_err", 64'(err_timeout), 64'h1);
    load(64'h6004);
    step(0, 0, 1, 0, 0, 64'h0, 64'h6008, 32'h0, 1);
    step(0, 0, 0, 1, 0, 64'h0, 64'h6008, 32'h0, 1);
    chk("wd_sticky", 64'(err_timeout), 64'h1);

    // saturation: 20 bubbles into a 4-bit counter
    do_reset();
    for (int i = 0; i < 10; i++) begin
      load(64'h7000);
      step(0, 0, 1, 0, 0, 64'h0, 64'h7004, 32'h0, 1);
      step(0, 0, 0, 1, 1, 64'h7100, 64'h7004, 32'h0, 1);
    end
    chk("sat_cnt", 64'(bubble_cnt), 64'hf);

    // reset in the middle of WAIT_BR
    load(64'h8000);
    step(0, 0, 1, 0, 0, 64'h0, 64'h8004, 32'h0, 1);
    do_reset();
    load(64'h9000);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           {$urandom, $urandom}, {$urandom, $urandom}, $urandom,
           $urandom_range(0, 7) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
